// File: rtl/spi_flash_pkg.sv
// Shared opcodes and FSM state encoding for the SPI flash responder.
package spi_flash_pkg;

  localparam logic [7:0] CMD_READ = 8'h03;
  localparam logic [7:0] CMD_RDID = 8'h9F;
  localparam logic [7:0] CMD_RDSR = 8'h05;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DATA,
    ID,
    STAT,
    IGNORE
  } state_t;

  // State entered once the full opcode has been shifted in.
  function automatic state_t decode_cmd(input logic [7:0] cmd);
    case (cmd)
      CMD_READ: return ADDR;
      CMD_RDID: return ID;
      CMD_RDSR: return STAT;
      default:  return IGNORE;
    endcase
  endfunction

endpackage

// File: rtl/spi_flash_responder_sync.sv
// Multi-stage input synchronizer with rise/fall pulses derived from the
// synchronized level.
module spi_pin_sync #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic [STAGES:0]   shifted;
  logic              prev;

  assign shifted = {chain, pin};

  // Shift the raw pin through the chain; keep last level for edge detect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain <= {STAGES{RESET_VAL}};
      prev  <= RESET_VAL;
    end else begin
      chain <= shifted[STAGES-1:0];
      prev  <= chain[STAGES-1];
    end
  end

  // Level and single-cycle edge pulses.
  always_comb begin
    level = chain[STAGES-1];
    rise  = chain[STAGES-1] & ~prev;
    fall  = ~chain[STAGES-1] & prev;
  end

endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 flash responder: READ (0x03), JEDEC ID (0x9F) and status
// (0x05), with a one-byte prefetch buffer in front of the backing store.
module spi_flash_responder
  import spi_flash_pkg::*;
#(
  parameter logic [23:0] JEDEC_ID    = 24'hEF4016,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk_48mhz,
  input  logic        reset,
  input  logic        spi_sck,
  input  logic        spi_cs,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        spi_miso_oe,
  output logic [23:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_data,
  input  logic        mem_ack,
  output logic        busy,
  output logic        underrun
);

  state_t      state, state_next;
  logic        sck_level, sck_rise, sck_fall;
  logic        cs_level, cs_rise, cs_fall;
  logic        mosi_level, mosi_rise, mosi_fall;
  logic        unused_edges;

  logic [22:0] rx_sr;
  logic [4:0]  bit_cnt;
  logic [2:0]  bit_idx;
  logic [1:0]  byte_cnt;
  logic [6:0]  tx_sr;
  logic        miso_q;

  logic        rd_q, rd_out, rd_stale, rd_pend, buf_valid, underrun_q;
  logic [23:0] addr_q, pend_addr, byte_addr;
  logic [7:0]  buf_data;

  logic [7:0]  cmd_byte, tx_byte, load_data;
  logic [23:0] rx_addr, want_addr, issue_addr;
  logic        rx_last, addr_done, data_load, ack_ok, starve;
  logic        want_rd, can_issue, issue;

  spi_pin_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck (
    .clk(clk_48mhz), .reset(reset), .pin(spi_sck),
    .level(sck_level), .rise(sck_rise), .fall(sck_fall)
  );
  spi_pin_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs (
    .clk(clk_48mhz), .reset(reset), .pin(spi_cs),
    .level(cs_level), .rise(cs_rise), .fall(cs_fall)
  );
  spi_pin_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_mosi (
    .clk(clk_48mhz), .reset(reset), .pin(spi_mosi),
    .level(mosi_level), .rise(mosi_rise), .fall(mosi_fall)
  );

  assign unused_edges = &{1'b0, sck_level, cs_rise, mosi_rise, mosi_fall};

  // State register.
  always_ff @(posedge clk_48mhz or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state: deasserted cs wins over everything outside IDLE.
  always_comb begin
    state_next = state;
    if (state == IDLE) begin
      if (cs_fall) state_next = CMD;
    end else if (cs_level) begin
      state_next = IDLE;
    end else begin
      case (state)
        CMD:     if (sck_rise && rx_last) state_next = decode_cmd(cmd_byte);
        ADDR:    if (addr_done) state_next = DATA;
        default: state_next = state;
      endcase
    end
  end

  // Outputs.
  always_comb begin
    spi_miso_oe = (state == DATA) || (state == ID) || (state == STAT);
    spi_miso    = miso_q;
    busy        = ~cs_level;
    mem_rd      = rd_q;
    mem_addr    = addr_q;
    underrun    = underrun_q;
  end

  // Datapath decode: byte selection and read-request arbitration.
  always_comb begin
    cmd_byte  = {rx_sr[6:0], mosi_level};
    rx_addr   = {rx_sr, mosi_level};
    rx_last   = (state == CMD) ? (bit_cnt == 5'd7) : (bit_cnt == 5'd23);
    addr_done = (state == ADDR) && sck_rise && (bit_cnt == 5'd23);
    data_load = (state == DATA) && sck_fall && (bit_idx == 3'd0);
    ack_ok    = mem_ack && rd_out && !rd_stale;
    starve    = !buf_valid && !ack_ok;
    // A same-cycle ack is forwarded straight to the shifter.
    load_data = buf_valid ? buf_data : (ack_ok ? mem_data : 8'hFF);

    tx_byte = 8'hFF;
    case (state)
      DATA: tx_byte = load_data;
      ID: begin
        case (byte_cnt)
          2'd0:    tx_byte = JEDEC_ID[23:16];
          2'd1:    tx_byte = JEDEC_ID[15:8];
          2'd2:    tx_byte = JEDEC_ID[7:0];
          default: tx_byte = 8'hFF;
        endcase
      end
      STAT:    tx_byte = 8'h00;
      default: tx_byte = 8'hFF;
    endcase

    want_rd   = addr_done || data_load;
    want_addr = addr_done ? rx_addr : byte_addr + 24'd1;
    // Only one read in flight: a new one may go out in the ack cycle.
    can_issue  = !rd_out || mem_ack;
    issue      = can_issue && (want_rd || (rd_pend && state != IDLE));
    issue_addr = want_rd ? want_addr : pend_addr;
  end

  // Shift registers: MOSI capture on sck rise, MISO launch on sck fall.
  always_ff @(posedge clk_48mhz or posedge reset) begin
    if (reset) begin
      rx_sr    <= '0;
      bit_cnt  <= '0;
      bit_idx  <= '0;
      byte_cnt <= '0;
      tx_sr    <= '1;
      miso_q   <= 1'b1;
    end else begin
      if (state == CMD || state == ADDR) begin
        if (sck_rise) begin
          rx_sr   <= rx_addr[22:0];
          bit_cnt <= rx_last ? 5'd0 : bit_cnt + 5'd1;
        end
      end else begin
        bit_cnt <= '0;
      end

      if (spi_miso_oe) begin
        if (sck_fall) begin
          if (bit_idx == 3'd0) begin
            miso_q <= tx_byte[7];
            tx_sr  <= tx_byte[6:0];
            if (byte_cnt != 2'd3) byte_cnt <= byte_cnt + 2'd1;
          end else begin
            miso_q <= tx_sr[6];
            tx_sr  <= {tx_sr[5:0], 1'b1};
          end
          bit_idx <= bit_idx + 3'd1;
        end
      end else begin
        miso_q   <= 1'b1;
        bit_idx  <= '0;
        byte_cnt <= '0;
      end
    end
  end

  // Backing-store reads, prefetch buffer and underrun tracking.
  always_ff @(posedge clk_48mhz or posedge reset) begin
    if (reset) begin
      rd_q       <= 1'b0;
      rd_out     <= 1'b0;
      rd_stale   <= 1'b0;
      rd_pend    <= 1'b0;
      buf_valid  <= 1'b0;
      underrun_q <= 1'b0;
      addr_q     <= '0;
      pend_addr  <= '0;
      byte_addr  <= '0;
      buf_data   <= '0;
    end else begin
      rd_q <= 1'b0;
      if (mem_ack) rd_out <= 1'b0;

      if (ack_ok && !data_load) begin
        buf_valid <= 1'b1;
        buf_data  <= mem_data;
      end

      // A late read belongs to a byte already sent as 0xFF: drop its data.
      if (data_load) begin
        buf_valid <= 1'b0;
        if (starve) begin
          underrun_q <= 1'b1;
          if (rd_out && !mem_ack) rd_stale <= 1'b1;
        end
      end

      if (state == IDLE) begin
        buf_valid <= 1'b0;
        rd_pend   <= 1'b0;
        if (rd_out && !mem_ack) rd_stale <= 1'b1;
      end

      if (issue) begin
        rd_q     <= 1'b1;
        addr_q   <= issue_addr;
        rd_out   <= 1'b1;
        rd_stale <= 1'b0;
        rd_pend  <= 1'b0;
      end else if (want_rd) begin
        rd_pend   <= 1'b1;
        pend_addr <= want_addr;
      end

      if (addr_done)      byte_addr <= rx_addr;
      else if (data_load) byte_addr <= byte_addr + 24'd1;
    end
  end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder: SPI master at clk/8, memory model
// with programmable ack latency.
module tb_spi_flash_responder;

  logic        clk_48mhz = 1'b0;
  logic        reset     = 1'b1;
  logic        spi_sck   = 1'b0;
  logic        spi_cs    = 1'b1;
  logic        spi_mosi  = 1'b0;
  logic        spi_miso, spi_miso_oe, mem_rd, busy, underrun;
  logic [23:0] mem_addr;
  logic [7:0]  mem_data  = 8'h00;
  logic        mem_ack   = 1'b0;

  int checks = 0;
  int errors = 0;

  int          ack_lat = 2;
  int          ack_cnt = 0;
  logic [23:0] ack_addr = '0;
  logic [23:0] rd_log[$];
  int          oe_count = 0;

  always #10 clk_48mhz = ~clk_48mhz;

  spi_flash_responder #(.JEDEC_ID(24'hEF4016), .SYNC_STAGES(2)) dut (
    .clk_48mhz(clk_48mhz), .reset(reset),
    .spi_sck(spi_sck), .spi_cs(spi_cs), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ack(mem_ack),
    .busy(busy), .underrun(underrun)
  );

  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    case (a)
      24'h000100: return 8'hA5;
      24'h000101: return 8'h5A;
      24'h000102: return 8'hC3;
      24'hFFFFFF: return 8'h3C;
      24'h000000: return 8'h96;
      default:    return a[7:0] ^ 8'h5C;
    endcase
  endfunction

  // Memory model: ack ack_lat cycles after the mem_rd strobe.
  always @(negedge clk_48mhz) begin
    if (spi_miso_oe === 1'b1) oe_count++;
    mem_ack = 1'b0;
    if (ack_cnt != 0) begin
      ack_cnt--;
      if (ack_cnt == 0) begin
        mem_ack  = 1'b1;
        mem_data = mem_byte(ack_addr);
      end
    end
    if (mem_rd === 1'b1) begin
      rd_log.push_back(mem_addr);
      ack_addr = mem_addr;
      if (ack_lat <= 1) begin
        mem_ack  = 1'b1;
        mem_data = mem_byte(mem_addr);
      end else begin
        ack_cnt = ack_lat - 1;
      end
    end
  end

  task automatic spi_bit(input logic b, output logic r);
    spi_mosi = b;
    repeat (4) @(negedge clk_48mhz);
    r = spi_miso;
    spi_sck = 1'b1;
    repeat (4) @(negedge clk_48mhz);
    spi_sck = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(tx[i], r);
      rx[i] = r;
    end
  endtask

  task automatic cs_start();
    spi_cs = 1'b0;
    repeat (4) @(negedge clk_48mhz);
  endtask

  // Leaves the bench SYNC_STAGES+1 cycles after cs rises.
  task automatic cs_stop();
    repeat (4) @(negedge clk_48mhz);
    spi_cs = 1'b1;
    repeat (3) @(negedge clk_48mhz);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk_48mhz);
    checks++; if (spi_miso !== 1'b1) begin errors++; $display("FAIL reset_miso got %b want 1", spi_miso); end
    checks++; if (spi_miso_oe !== 1'b0) begin errors++; $display("FAIL reset_oe got %b want 0", spi_miso_oe); end
    checks++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL reset_mem_rd got %b want 0", mem_rd); end
    checks++; if (mem_addr !== 24'h0) begin errors++; $display("FAIL reset_mem_addr got %h want 000000", mem_addr); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun got %b want 0", underrun); end
    reset = 1'b0;
    repeat (4) @(negedge clk_48mhz);
  endtask

  task automatic test_read();
    logic [7:0] rx;
    logic [7:0] exp_b [3];
    int base;
    exp_b = '{8'hA5, 8'h5A, 8'hC3};
    ack_lat = 2;
    base = rd_log.size();
    cs_start();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL read_busy got %b want 1", busy); end
    spi_byte(8'h03, rx); spi_byte(8'h00, rx); spi_byte(8'h01, rx); spi_byte(8'h00, rx);
    for (int k = 0; k < 3; k++) begin
      spi_byte(8'h00, rx);
      checks++; if (rx !== exp_b[k]) begin errors++; $display("FAIL read_byte%0d got %h want %h", k, rx, exp_b[k]); end
    end
    checks++; if (spi_miso_oe !== 1'b1) begin errors++; $display("FAIL read_oe got %b want 1", spi_miso_oe); end
    cs_stop();
    checks++; if (spi_miso_oe !== 1'b0) begin errors++; $display("FAIL read_oe_drop got %b want 0", spi_miso_oe); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL read_busy_drop got %b want 0", busy); end
    repeat (8) @(negedge clk_48mhz);
    checks++;
    if (rd_log.size() < base + 3) begin
      errors++; $display("FAIL read_rd_count got %0d want >=3", rd_log.size() - base);
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (rd_log[base + k] !== 24'h000100 + 24'(k)) begin
          errors++; $display("FAIL read_addr%0d got %h want %h", k, rd_log[base + k], 24'h000100 + 24'(k));
        end
      end
    end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL read_underrun got %b want 0", underrun); end
  endtask

  task automatic test_jedec();
    logic [7:0] rx;
    logic [7:0] exp_b [5];
    int base;
    exp_b = '{8'hEF, 8'h40, 8'h16, 8'hFF, 8'hFF};
    base = rd_log.size();
    cs_start();
    spi_byte(8'h9F, rx);
    for (int k = 0; k < 5; k++) begin
      spi_byte(8'h00, rx);
      checks++; if (rx !== exp_b[k]) begin errors++; $display("FAIL jedec_byte%0d got %h want %h", k, rx, exp_b[k]); end
    end
    cs_stop();
    repeat (8) @(negedge clk_48mhz);
    checks++; if (rd_log.size() != base) begin errors++; $display("FAIL jedec_no_rd got %0d want 0", rd_log.size() - base); end
  endtask

  task automatic test_wrap();
    logic [7:0] rx;
    logic [7:0] exp_b [2];
    int base;
    exp_b = '{8'h3C, 8'h96};
    ack_lat = 4;
    base = rd_log.size();
    cs_start();
    spi_byte(8'h03, rx); spi_byte(8'hFF, rx); spi_byte(8'hFF, rx); spi_byte(8'hFF, rx);
    for (int k = 0; k < 2; k++) begin
      spi_byte(8'h00, rx);
      checks++; if (rx !== exp_b[k]) begin errors++; $display("FAIL wrap_byte%0d got %h want %h", k, rx, exp_b[k]); end
    end
    cs_stop();
    repeat (8) @(negedge clk_48mhz);
    checks++;
    if (rd_log.size() < base + 2) begin
      errors++; $display("FAIL wrap_rd_count got %0d want >=2", rd_log.size() - base);
    end else begin
      checks++; if (rd_log[base] !== 24'hFFFFFF) begin errors++; $display("FAIL wrap_addr0 got %h want ffffff", rd_log[base]); end
      checks++; if (rd_log[base + 1] !== 24'h000000) begin errors++; $display("FAIL wrap_addr1 got %h want 000000", rd_log[base + 1]); end
    end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL wrap_underrun got %b want 0", underrun); end
  endtask

  task automatic test_underrun();
    logic [7:0] rx;
    ack_lat = 40;
    cs_start();
    spi_byte(8'h03, rx); spi_byte(8'h00, rx); spi_byte(8'h02, rx); spi_byte(8'h00, rx);
    for (int k = 0; k < 2; k++) begin
      spi_byte(8'h00, rx);
      checks++; if (rx !== 8'hFF) begin errors++; $display("FAIL underrun_byte%0d got %h want ff", k, rx); end
    end
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL underrun_flag got %b want 1", underrun); end
    cs_stop();
    repeat (60) @(negedge clk_48mhz);
    ack_lat = 2;
    cs_start();
    spi_byte(8'h05, rx);
    spi_byte(8'h00, rx);
    checks++; if (rx !== 8'h00) begin errors++; $display("FAIL underrun_stat got %h want 00", rx); end
    cs_stop();
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL underrun_sticky got %b want 1", underrun); end
    repeat (8) @(negedge clk_48mhz);
  endtask

  task automatic test_ignore();
    logic [7:0] rx;
    int oe_base;
    oe_base = oe_count;
    cs_start();
    spi_byte(8'hAB, rx);
    spi_byte(8'h00, rx);
    spi_byte(8'h00, rx);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ignore_busy got %b want 1", busy); end
    cs_stop();
    repeat (8) @(negedge clk_48mhz);
    checks++; if (oe_count != oe_base) begin errors++; $display("FAIL ignore_oe got %0d cycles want 0", oe_count - oe_base); end
  endtask

  task automatic test_abort();
    logic [7:0] rx;
    logic r;
    logic [11:0] abits;
    int base;
    abits = 12'h004;
    base = rd_log.size();
    cs_start();
    spi_byte(8'h03, rx);
    for (int i = 11; i >= 0; i--) spi_bit(abits[i], r);
    cs_stop();
    checks++; if (spi_miso_oe !== 1'b0) begin errors++; $display("FAIL abort_oe got %b want 0", spi_miso_oe); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
    repeat (8) @(negedge clk_48mhz);
    checks++; if (rd_log.size() != base) begin errors++; $display("FAIL abort_no_rd got %0d want 0", rd_log.size() - base); end
    cs_start();
    spi_byte(8'h05, rx);
    spi_byte(8'h00, rx);
    checks++; if (rx !== 8'h00) begin errors++; $display("FAIL abort_stat got %h want 00", rx); end
    checks++; if (spi_miso_oe !== 1'b1) begin errors++; $display("FAIL abort_stat_oe got %b want 1", spi_miso_oe); end
    cs_stop();
    repeat (8) @(negedge clk_48mhz);
  endtask

  task automatic test_cs_only();
    logic [7:0] rx;
    int base, oe_base;
    base = rd_log.size();
    oe_base = oe_count;
    spi_cs = 1'b0;
    repeat (10) @(negedge clk_48mhz);
    spi_cs = 1'b1;
    repeat (8) @(negedge clk_48mhz);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL csonly_busy got %b want 0", busy); end
    checks++; if (rd_log.size() != base) begin errors++; $display("FAIL csonly_no_rd got %0d want 0", rd_log.size() - base); end
    checks++; if (oe_count != oe_base) begin errors++; $display("FAIL csonly_oe got %0d cycles want 0", oe_count - oe_base); end
    cs_start();
    spi_byte(8'h9F, rx);
    spi_byte(8'h00, rx);
    checks++; if (rx !== 8'hEF) begin errors++; $display("FAIL csonly_jedec got %h want ef", rx); end
    cs_stop();
    repeat (8) @(negedge clk_48mhz);
  endtask

  task automatic test_reset_mid();
    logic [7:0] rx;
    logic r;
    cs_start();
    spi_byte(8'h9F, rx);
    for (int i = 0; i < 4; i++) spi_bit(1'b0, r);
    reset = 1'b1;
    spi_cs = 1'b1;
    spi_sck = 1'b0;
    #1;
    checks++; if (spi_miso_oe !== 1'b0) begin errors++; $display("FAIL rstmid_oe got %b want 0", spi_miso_oe); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL rstmid_underrun got %b want 0", underrun); end
    checks++; if (spi_miso !== 1'b1) begin errors++; $display("FAIL rstmid_miso got %b want 1", spi_miso); end
    repeat (2) @(negedge clk_48mhz);
    reset = 1'b0;
    repeat (4) @(negedge clk_48mhz);
    cs_start();
    spi_byte(8'h05, rx);
    spi_byte(8'h00, rx);
    checks++; if (rx !== 8'h00) begin errors++; $display("FAIL rstmid_stat got %h want 00", rx); end
    cs_stop();
    repeat (8) @(negedge clk_48mhz);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_read();
    test_jedec();
    test_wrap();
    test_underrun();
    test_ignore();
    test_abort();
    test_cs_only();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
